// File: rtl/apb_uart_regs.sv
// APB3 register front-end for the UART controller.
// Turns CPU bus transfers into tx push / rx pop strobes and holds the baud
// divisor, interrupt enables and a sticky rx-overrun flag. The slave never
// inserts wait states. Read data and the error response are combinational.
// Strobes and register updates are registered.
module apb_uart_regs #(
    parameter int          ADDR_WIDTH   = 4,
    parameter logic [10:0] BAUD_DEFAULT = 11'd650
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  tx_fifo_writeEn,
    output logic [7:0]            tx_fifo_dataIn,
    output logic                  rx_fifo_readEn,
    input  logic [7:0]            rx_fifo_dataOut,
    input  logic                  tx_full,
    input  logic                  tx_empty,
    input  logic                  rx_full,
    input  logic                  rx_empty,
    input  logic                  rx_overrun,
    output logic [10:0]           baud_final_value,
    output logic                  irq
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    state_t      state;
    logic [1:0]  ctrl;
    logic        ovr;
    logic        access_phase;
    logic        xfer;
    logic [1:0]  reg_sel;
    logic        data_wr_ok;
    logic        data_rd_ok;
    logic        status_w1c;
    logic [10:0] baud_wdata;
    logic        unused_bits;

    // Only the word index of the address is decoded; the byte offset and the
    // upper write-data bits have no meaning for any register.
    assign unused_bits = ^{PADDR, PWDATA[31:11]};

    assign reg_sel      = PADDR[3:2];
    assign access_phase = PSEL && PENABLE;
    assign xfer         = access_phase && (state == SETUP);
    assign data_wr_ok   = xfer && PWRITE && (reg_sel == REG_DATA) && !tx_full;
    assign data_rd_ok   = xfer && !PWRITE && (reg_sel == REG_DATA) && !rx_empty;
    assign status_w1c   = xfer && PWRITE && (reg_sel == REG_STATUS) && PWDATA[4];
    assign baud_wdata   = (PWDATA[10:0] == 11'd0) ? 11'd1 : PWDATA[10:0];
    assign PREADY       = 1'b1;

    // Track the APB phase so a transfer is accepted only after a proper setup cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= (PSEL && !PENABLE) ? SETUP : IDLE;
                SETUP:   state <= (PSEL && PENABLE) ? ACCESS : IDLE;
                ACCESS:  state <= (PSEL && !PENABLE) ? SETUP : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read mux and error response, driven only during an access phase.
    always_comb begin
        PRDATA  = 32'd0;
        PSLVERR = 1'b0;
        if (access_phase && (state != SETUP)) begin
            PSLVERR = 1'b1;
        end else if (xfer) begin
            case (reg_sel)
                REG_DATA: begin
                    if (PWRITE) begin
                        PSLVERR = tx_full;
                    end else if (rx_empty) begin
                        PSLVERR = 1'b1;
                    end else begin
                        PRDATA = {24'd0, rx_fifo_dataOut};
                    end
                end
                REG_STATUS: begin
                    if (!PWRITE) begin
                        PRDATA = {27'd0, ovr, rx_empty, rx_full, tx_empty, tx_full};
                    end
                end
                REG_CTRL: begin
                    if (!PWRITE) begin
                        PRDATA = {30'd0, ctrl};
                    end
                end
                default: begin
                    if (!PWRITE) begin
                        PRDATA = {21'd0, baud_final_value};
                    end
                end
            endcase
        end
    end

    // One-cycle FIFO strobes following a completed DATA transfer; the pushed byte is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_fifo_writeEn <= 1'b0;
            tx_fifo_dataIn  <= 8'd0;
            rx_fifo_readEn  <= 1'b0;
        end else begin
            tx_fifo_writeEn <= data_wr_ok;
            rx_fifo_readEn  <= data_rd_ok;
            if (data_wr_ok) begin
                tx_fifo_dataIn <= PWDATA[7:0];
            end
        end
    end

    // Control and baud registers; a zero divisor is bumped to 1 so the tick never stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl             <= 2'd0;
            baud_final_value <= BAUD_DEFAULT;
        end else if (xfer && PWRITE) begin
            if (reg_sel == REG_CTRL) begin
                ctrl <= PWDATA[1:0];
            end
            if (reg_sel == REG_BAUD) begin
                baud_final_value <= baud_wdata;
            end
        end
    end

    // Sticky overrun flag; a new overrun beats a simultaneous clear so no event is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr <= 1'b0;
        end else if (rx_overrun) begin
            ovr <= 1'b1;
        end else if (status_w1c) begin
            ovr <= 1'b0;
        end
    end

    // Registered level interrupt from the enabled FIFO conditions and the overrun flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else begin
            irq <= (ctrl[0] && !rx_empty) || (ctrl[1] && tx_empty) || ovr;
        end
    end

endmodule

// File: tb/tb_apb_uart_regs.sv
// Testbench for apb_uart_regs: directed APB transfers with literal expectations,
// plus a cycle-level reference model that is compared against every DUT output
// on each falling clock edge.
module tb_apb_uart_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        tx_fifo_writeEn;
    logic [7:0]  tx_fifo_dataIn;
    logic        rx_fifo_readEn;
    logic [7:0]  rx_fifo_dataOut;
    logic        tx_full;
    logic        tx_empty;
    logic        rx_full;
    logic        rx_empty;
    logic        rx_overrun;
    logic [10:0] baud_final_value;
    logic        irq;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic        m_in_setup;
    logic        m_tx_we;
    logic [7:0]  m_tx_data;
    logic        m_rx_re;
    logic [1:0]  m_ctrl;
    logic        m_ovr;
    logic [10:0] m_baud;
    logic        m_irq;

    logic [31:0] rdata;
    logic        err;

    apb_uart_regs #(.ADDR_WIDTH(4), .BAUD_DEFAULT(11'd650)) dut (
        .clk              (clk),
        .reset            (reset),
        .PSEL             (PSEL),
        .PENABLE          (PENABLE),
        .PWRITE           (PWRITE),
        .PADDR            (PADDR),
        .PWDATA           (PWDATA),
        .PRDATA           (PRDATA),
        .PREADY           (PREADY),
        .PSLVERR          (PSLVERR),
        .tx_fifo_writeEn  (tx_fifo_writeEn),
        .tx_fifo_dataIn   (tx_fifo_dataIn),
        .rx_fifo_readEn   (rx_fifo_readEn),
        .rx_fifo_dataOut  (rx_fifo_dataOut),
        .tx_full          (tx_full),
        .tx_empty         (tx_empty),
        .rx_full          (rx_full),
        .rx_empty         (rx_empty),
        .rx_overrun       (rx_overrun),
        .baud_final_value (baud_final_value),
        .irq              (irq)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected read data / error from the register map rules and the model state
    function automatic logic [32:0] model_response();
        logic [31:0] d;
        logic        e;
        d = 32'd0;
        e = 1'b0;
        if (PSEL && PENABLE) begin
            if (!m_in_setup) begin
                e = 1'b1;
            end else if (PADDR[3:2] == 2'd0) begin
                if (PWRITE) e = tx_full;
                else if (rx_empty) e = 1'b1;
                else d = 32'(rx_fifo_dataOut);
            end else if (!PWRITE) begin
                if (PADDR[3:2] == 2'd1)
                    d = 32'(tx_full) + 32'(tx_empty) * 2 + 32'(rx_full) * 4
                        + 32'(rx_empty) * 8 + 32'(m_ovr) * 16;
                else if (PADDR[3:2] == 2'd2) d = 32'(m_ctrl);
                else d = 32'(m_baud);
            end
        end
        return {e, d};
    endfunction

    // Reference model: what each registered output must become after an edge
    always @(posedge clk or negedge reset) begin
        logic done;
        logic next_irq;
        if (!reset) begin
            m_in_setup = 1'b0;
            m_tx_we    = 1'b0;
            m_tx_data  = 8'd0;
            m_rx_re    = 1'b0;
            m_ctrl     = 2'd0;
            m_ovr      = 1'b0;
            m_baud     = 11'd650;
            m_irq      = 1'b0;
        end else begin
            next_irq = (m_ctrl[0] && !rx_empty) || (m_ctrl[1] && tx_empty) || m_ovr;
            done     = PSEL && PENABLE && m_in_setup;
            m_tx_we  = done && PWRITE && (PADDR[3:2] == 2'd0) && !tx_full;
            m_rx_re  = done && !PWRITE && (PADDR[3:2] == 2'd0) && !rx_empty;
            if (m_tx_we) m_tx_data = PWDATA[7:0];
            if (rx_overrun) m_ovr = 1'b1;
            else if (done && PWRITE && PADDR[3:2] == 2'd1 && PWDATA[4]) m_ovr = 1'b0;
            if (done && PWRITE && PADDR[3:2] == 2'd2) m_ctrl = PWDATA[1:0];
            if (done && PWRITE && PADDR[3:2] == 2'd3)
                m_baud = (PWDATA[10:0] == 11'd0) ? 11'd1 : PWDATA[10:0];
            m_irq      = next_irq;
            m_in_setup = PSEL && !PENABLE && !m_in_setup;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model
    always @(negedge clk) begin
        logic [32:0] resp;
        resp = model_response();
        check_output("PRDATA", PRDATA, resp[31:0]);
        check_output("PSLVERR", 32'(PSLVERR), 32'(resp[32]));
        check_output("PREADY", 32'(PREADY), 32'd1);
        check_output("tx_fifo_writeEn", 32'(tx_fifo_writeEn), 32'(m_tx_we));
        check_output("tx_fifo_dataIn", 32'(tx_fifo_dataIn), 32'(m_tx_data));
        check_output("rx_fifo_readEn", 32'(rx_fifo_readEn), 32'(m_rx_re));
        check_output("baud_final_value", 32'(baud_final_value), 32'(m_baud));
        check_output("irq", 32'(irq), 32'(m_irq));
    end

    // One complete APB transfer; returns just after the completion edge
    task automatic apply_stimulus(input logic wr, input logic [3:0] addr,
                                  input logic [31:0] data, input logic pulse_ovr,
                                  output logic [31:0] rd, output logic er);
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
        @(posedge clk); #1;
        PENABLE = 1'b1; rx_overrun = pulse_ovr;
        @(negedge clk);
        rd = PRDATA;
        er = PSLVERR;
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; rx_overrun = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'd0; PWDATA = 32'd0;
        rx_fifo_dataOut = 8'd0;
        tx_full = 1'b0; tx_empty = 1'b1; rx_full = 1'b0; rx_empty = 1'b1; rx_overrun = 1'b0;

        repeat (3) @(negedge clk);
        check_output("reset baud", 32'(baud_final_value), 32'd650);
        check_output("reset irq", 32'(irq), 32'd0);
        check_output("reset tx strobe", 32'(tx_fifo_writeEn), 32'd0);
        @(posedge clk); #1 reset = 1'b1;

        // Reset values visible through the bus
        apply_stimulus(1'b0, 4'hC, 32'd0, 1'b0, rdata, err);
        check_output("read BAUD", rdata, 32'd650);
        apply_stimulus(1'b0, 4'h8, 32'd0, 1'b0, rdata, err);
        check_output("read CTRL", rdata, 32'd0);

        // DATA push
        apply_stimulus(1'b1, 4'h0, 32'h0000_0055, 1'b0, rdata, err);
        check_output("push err", 32'(err), 32'd0);
        @(negedge clk);
        check_output("push strobe", 32'(tx_fifo_writeEn), 32'd1);
        check_output("push byte", 32'(tx_fifo_dataIn), 32'h55);
        @(negedge clk);
        check_output("push strobe width", 32'(tx_fifo_writeEn), 32'd0);

        // DATA push while tx FIFO is full
        tx_full = 1'b1;
        apply_stimulus(1'b1, 4'h0, 32'h0000_000F, 1'b0, rdata, err);
        check_output("full push err", 32'(err), 32'd1);
        @(negedge clk);
        check_output("full push strobe", 32'(tx_fifo_writeEn), 32'd0);
        check_output("full push byte held", 32'(tx_fifo_dataIn), 32'h55);
        tx_full = 1'b0;

        // DATA pop, then pop from an empty FIFO
        rx_fifo_dataOut = 8'hF0; rx_empty = 1'b0;
        apply_stimulus(1'b0, 4'h1, 32'd0, 1'b0, rdata, err);
        check_output("pop data", rdata, 32'hF0);
        check_output("pop err", 32'(err), 32'd0);
        @(negedge clk);
        check_output("pop strobe", 32'(rx_fifo_readEn), 32'd1);
        rx_empty = 1'b1;
        apply_stimulus(1'b0, 4'h0, 32'd0, 1'b0, rdata, err);
        check_output("empty pop data", rdata, 32'd0);
        check_output("empty pop err", 32'(err), 32'd1);
        @(negedge clk);
        check_output("empty pop strobe", 32'(rx_fifo_readEn), 32'd0);

        // Baud divisor, including the zero clamp
        apply_stimulus(1'b1, 4'hC, 32'h0000_028B, 1'b0, rdata, err);
        @(negedge clk);
        check_output("baud 651", 32'(baud_final_value), 32'd651);
        apply_stimulus(1'b1, 4'hF, 32'hFFFF_F800, 1'b0, rdata, err);
        @(negedge clk);
        check_output("baud zero clamp", 32'(baud_final_value), 32'd1);

        // rx interrupt enable: irq follows rx_empty one cycle late
        apply_stimulus(1'b1, 4'h8, 32'd1, 1'b0, rdata, err);
        @(negedge clk);
        check_output("irq idle", 32'(irq), 32'd0);
        @(posedge clk); #1 rx_empty = 1'b0;
        @(negedge clk);
        check_output("irq not yet", 32'(irq), 32'd0);
        @(negedge clk);
        check_output("irq rx", 32'(irq), 32'd1);
        @(posedge clk); #1 rx_empty = 1'b1;
        repeat (2) @(negedge clk);

        // Overrun pulse on the same edge as the clear: set wins
        apply_stimulus(1'b1, 4'h4, 32'h0000_001F, 1'b1, rdata, err);
        apply_stimulus(1'b0, 4'h4, 32'd0, 1'b0, rdata, err);
        check_output("status ovr set", rdata, 32'h1A);
        check_output("irq ovr", 32'(irq), 32'd1);
        apply_stimulus(1'b1, 4'h4, 32'h0000_0010, 1'b0, rdata, err);
        apply_stimulus(1'b0, 4'h4, 32'd0, 1'b0, rdata, err);
        check_output("status ovr clear", rdata, 32'h0A);

        // Access phase without setup: error, no write
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 4'hC; PWDATA = 32'd5;
        @(negedge clk);
        check_output("protocol err", 32'(PSLVERR), 32'd1);
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge clk);
        check_output("protocol no write", 32'(baud_final_value), 32'd1);

        // Reset while a push strobe is live
        apply_stimulus(1'b1, 4'h0, 32'h0000_00A5, 1'b0, rdata, err);
        reset = 1'b0;
        #1;
        check_output("reset drops strobe", 32'(tx_fifo_writeEn), 32'd0);
        check_output("reset byte", 32'(tx_fifo_dataIn), 32'd0);
        check_output("reset baud again", 32'(baud_final_value), 32'd650);
        @(posedge clk); #1 reset = 1'b1;
        apply_stimulus(1'b0, 4'h8, 32'd0, 1'b0, rdata, err);
        check_output("reset ctrl", rdata, 32'd0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
